pool_fm_pingpong: RTL and testbench



---
 rtl/cnn_pkg.sv | 18 +
 rtl/pingpong_bank_ram.sv | 27 ++
 rtl/pool_fm_pingpong.sv | 180 ++++++++++++++++++
 tb/tb_pool_fm_pingpong.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN buffer types: word width, data type, replay FSM states and an address-width helper.
package cnn_pkg;

    localparam int unsigned N_DATA = 32;

    typedef logic [N_DATA-1:0] data_t;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Address width that stays at least one bit for single-word banks.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pingpong_bank_ram.sv
// Two-bank register array: one synchronous write port, one asynchronous read port. Contents are not reset.
module pingpong_bank_ram #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/pool_fm_pingpong.sv
// Ping-pong capture of pooled feature-map frames with valid/ready replay of each completed frame.
// Optional build macro POOL_BUF_RELU_EN clamps negative words to zero on write.
module pool_fm_pingpong #(
    parameter int unsigned N_DATA  = cnn_pkg::N_DATA,
    parameter int unsigned OUT_ROW = 4,
    parameter int unsigned OUT_COL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_DATA-1:0] data_in,
    input  logic              data_in_vld,
    input  logic              data_in_end,
    output logic [N_DATA-1:0] data_out,
    output logic              data_out_vld,
    input  logic              data_out_rdy,
    output logic              data_out_last,
    output logic              buf_free,
    output logic              err_ovf,
    output logic              err_frame,
    input  logic              err_clr
);
    import cnn_pkg::*;

    localparam int unsigned DEPTH = OUT_ROW * OUT_COL;
    localparam int unsigned AW    = addr_w(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    rd_state_t         state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [N_DATA-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              frm_q, frm_d;

    logic              rd_release;
    logic              wr_acc;
    logic              wr_last;
    logic [AW-1:0]     rd_next;
    logic [AW-1:0]     ram_raddr;
    logic [N_DATA-1:0] ram_rdata;
    logic [N_DATA-1:0] wdata;

    // A bank being released this cycle may be refilled on the same edge.
    assign rd_release = (state_q == RD_STREAM) && vld_q && data_out_rdy && last_q;
    assign wr_acc     = data_in_vld &&
                        (!bank_full_q[wr_bank_q] || (rd_release && (rd_bank_q == wr_bank_q)));
    assign wr_last    = (wr_addr_q == LAST_ADDR);
    assign rd_next    = rd_addr_q + AW'(1);
    assign ram_raddr  = (state_q == RD_IDLE) ? '0 : rd_next;

`ifdef POOL_BUF_RELU_EN
    assign wdata = data_in[N_DATA-1] ? '0 : data_in;
`else
    assign wdata = data_in;
`endif

    pingpong_bank_ram #(
        .W     (N_DATA),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (wr_acc),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wdata),
        .rbank_i (rd_bank_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Write side, bank occupancy and sticky error flags.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        bank_full_d = bank_full_q;
        ovf_d       = ovf_q;
        frm_d       = frm_q;
        if (rd_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (wr_acc) begin
            if (wr_last) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                wr_addr_d              = '0;
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            frm_d = 1'b0;
        end
        if (data_in_vld && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (data_in_end && (!data_in_vld || (wr_acc && !wr_last))) begin
            frm_d = 1'b1;
        end
    end

    // Replay FSM: output registers only advance on a handshake.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        last_d    = last_q;
        case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    dout_d    = ram_rdata;
                    vld_d     = 1'b1;
                    last_d    = (DEPTH == 1);
                    rd_addr_d = '0;
                    state_d   = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (vld_q && data_out_rdy) begin
                    if (last_q) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_addr_d = '0;
                        vld_d     = 1'b0;
                        last_d    = 1'b0;
                        state_d   = RD_IDLE;
                    end else begin
                        dout_d    = ram_rdata;
                        rd_addr_d = rd_next;
                        last_d    = (rd_next == LAST_ADDR);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RD_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            bank_full_q <= 2'b00;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            frm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            bank_full_q <= bank_full_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            frm_q       <= frm_d;
        end
    end

    assign data_out      = dout_q;
    assign data_out_vld  = vld_q;
    assign data_out_last = last_q;
    assign err_ovf       = ovf_q;
    assign err_frame     = frm_q;
    assign buf_free      = !bank_full_q[wr_bank_q];

endmodule

// File: tb/tb_pool_fm_pingpong.sv
// Bench for pool_fm_pingpong: frame-level reference model (queues of stored frames and their
// earliest replay cycle) stepped once per clock, plus directed and randomized scenarios.
module tb_pool_fm_pingpong;

    localparam int unsigned NW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [NW-1:0] data_in;
    logic          data_in_vld;
    logic          data_in_end;
    logic [NW-1:0] data_out;
    logic          data_out_vld;
    logic          data_out_rdy;
    logic          data_out_last;
    logic          buf_free;
    logic          err_ovf;
    logic          err_frame;
    logic          err_clr;

    pool_fm_pingpong #(
        .N_DATA  (NW),
        .OUT_ROW (4),
        .OUT_COL (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .data_in       (data_in),
        .data_in_vld   (data_in_vld),
        .data_in_end   (data_in_end),
        .data_out      (data_out),
        .data_out_vld  (data_out_vld),
        .data_out_rdy  (data_out_rdy),
        .data_out_last (data_out_last),
        .buf_free      (buf_free),
        .err_ovf       (err_ovf),
        .err_frame     (err_frame),
        .err_clr       (err_clr)
    );

    always #5 i_clk = ~i_clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            pat_i = 0;
    logic [NW-1:0] exp_q[$];   // words of complete, not yet released frames
    int            favail[$];  // per stored frame: first cycle its replay may be visible
    logic [NW-1:0] cur[$];     // partially received frame
    int            out_idx;
    logic          e_ovf;
    logic          e_frm;

    function automatic logic [NW-1:0] ref_store(input logic [NW-1:0] d);
`ifdef POOL_BUF_RELU_EN
        return d[NW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        favail.delete();
        cur.delete();
        out_idx = 0;
        e_ovf   = 1'b0;
        e_frm   = 1'b0;
        cyc     = 0;
    endtask

    // Drive one clock's inputs at the falling edge, compare the outputs, advance the model.
    task automatic cycle(input logic v, input logic [NW-1:0] d, input logic e,
                         input logic r, input logic c);
        logic exp_vld, rel, acc, s_ovf, s_frm;
        int   nfr;
        data_in_vld  = v;
        data_in      = d;
        data_in_end  = e;
        data_out_rdy = r;
        err_clr      = c;
        nfr     = favail.size();
        exp_vld = 1'b0;
        if (nfr > 0) exp_vld = (cyc >= favail[0]);
        n_vec++;
        if (data_out_vld !== exp_vld) begin
            n_err++;
            $display("FAIL vld cyc=%0d got=%b exp=%b", cyc, data_out_vld, exp_vld);
        end
        if (exp_vld) begin
            n_vec++;
            if (data_out !== exp_q[0]) begin
                n_err++;
                $display("FAIL data cyc=%0d got=%h exp=%h", cyc, data_out, exp_q[0]);
            end
            n_vec++;
            if (data_out_last !== (out_idx == DEPTH - 1)) begin
                n_err++;
                $display("FAIL last cyc=%0d got=%b exp=%b", cyc, data_out_last, out_idx == DEPTH - 1);
            end
        end else begin
            n_vec++;
            if (data_out_last !== 1'b0) begin
                n_err++;
                $display("FAIL last_idle cyc=%0d got=%b exp=0", cyc, data_out_last);
            end
        end
        n_vec++;
        if (buf_free !== (nfr != 2)) begin
            n_err++;
            $display("FAIL buf_free cyc=%0d got=%b exp=%b", cyc, buf_free, nfr != 2);
        end
        n_vec++;
        if (err_ovf !== e_ovf || err_frame !== e_frm) begin
            n_err++;
            $display("FAIL err_flags cyc=%0d got=%b%b exp=%b%b", cyc, err_ovf, err_frame, e_ovf, e_frm);
        end
        rel = 1'b0;
        if (exp_vld && r) begin
            void'(exp_q.pop_front());
            out_idx++;
            if (out_idx == DEPTH) begin
                out_idx = 0;
                rel     = 1'b1;
            end
        end
        acc   = v && ((nfr < 2) || rel);
        s_ovf = v && !acc;
        s_frm = e && (!v || (acc && cur.size() != DEPTH - 1));
        if (rel) begin
            void'(favail.pop_front());
            if (favail.size() > 0 && favail[0] < cyc + 2) favail[0] = cyc + 2;
        end
        if (acc) begin
            cur.push_back(ref_store(d));
            if (cur.size() == DEPTH) begin
                foreach (cur[i]) exp_q.push_back(cur[i]);
                favail.push_back(cyc + 2);
                cur.delete();
            end
        end
        if (c) begin
            e_ovf = 1'b0;
            e_frm = 1'b0;
        end
        if (s_ovf) e_ovf = 1'b1;
        if (s_frm) e_frm = 1'b1;
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    function automatic logic rdy_pat();
        int p;
        p = pat_i % 4;
        pat_i++;
        return (p == 0) || (p == 3);
    endfunction

    // mode 0: rdy=1, mode 1: 1,0,0,1 pattern, mode 2: random
    task automatic drain(input int mode);
        logic r;
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? rdy_pat() : 1'($urandom_range(0, 1));
            cycle(1'b0, '0, 1'b0, r, 1'b0);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout words_left got=%0d exp=0", exp_q.size());
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        i_rst_n      = 1'b0;
        data_in      = '0;
        data_in_vld  = 1'b0;
        data_in_end  = 1'b0;
        data_out_rdy = 1'b0;
        err_clr      = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        n_vec++;
        if (data_out !== '0 || data_out_vld !== 1'b0 || data_out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out got=%h/%b/%b exp=0/0/0", data_out, data_out_vld, data_out_last);
        end
        n_vec++;
        if (buf_free !== 1'b1 || err_ovf !== 1'b0 || err_frame !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status got=%b%b%b exp=100", buf_free, err_ovf, err_frame);
        end
    endtask

    task automatic test_single_frame();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(i), i == DEPTH, 1'b1, 1'b0);
        n_vec++;
        if (data_out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got=%b exp=0", data_out_vld);
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (data_out_vld !== 1'b1 || data_out !== NW'(1)) begin
            n_err++;
            $display("FAIL latency_first got=%b/%h exp=1/00000001", data_out_vld, data_out);
        end
        drain(0);
    endtask

    task automatic test_rdy_pattern();
        pat_i = 0;
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(i), i == DEPTH, rdy_pat(), 1'b0);
        drain(1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(i), i == DEPTH, 1'b0, 1'b0);
        for (int i = 101; i <= 100 + DEPTH; i++) cycle(1'b1, NW'(i), i == 100 + DEPTH, 1'b0, 1'b0);
        n_vec++;
        if (buf_free !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_buf_free got=%b exp=0", buf_free);
        end
        cycle(1'b1, NW'(201), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (err_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got=%b exp=1", err_ovf);
        end
        cycle(1'b1, NW'(202), 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (err_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_beats_clr got=%b exp=1", err_ovf);
        end
        drain(0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr got=%b exp=0", err_ovf);
        end
    endtask

    task automatic test_frame_err();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(300 + i), i == 10, 1'b1, 1'b0);
        n_vec++;
        if (err_frame !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err got=%b exp=1", err_frame);
        end
        drain(0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (err_frame !== 1'b0) begin
            n_err++;
            $display("FAIL frame_err_clr got=%b exp=0", err_frame);
        end
    endtask

    task automatic test_relu();
        cycle(1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i < DEPTH; i++) cycle(1'b1, NW'($urandom), i == DEPTH - 1, 1'b1, 1'b0);
        drain(0);
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(i), i == DEPTH, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) cycle(1'b1, NW'(400 + i), 1'b0, 1'b1, 1'b0);
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if (data_out !== '0 || data_out_vld !== 1'b0 || data_out_last !== 1'b0 || buf_free !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset got=%h/%b/%b/%b exp=0/0/0/1", data_out, data_out_vld,
                     data_out_last, buf_free);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NW'(i), i == DEPTH, 1'b1, 1'b0);
        drain(0);
    endtask

    task automatic test_random();
        logic v, e, r, c;
        int   thr;
        thr = 5;
        for (int k = 0; k < 900; k++) begin
            if (k % 100 == 0) thr = $urandom_range(0, 10);
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 39) == 0) ? 1'b1 : (v && cur.size() == DEPTH - 1);
            r = ($urandom_range(0, 9) < thr);
            c = ($urandom_range(0, 29) == 0);
            cycle(v, NW'($urandom), e, r, c);
        end
        drain(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge i_clk);
        test_reset();
        test_single_frame();
        test_rdy_pattern();
        test_overflow();
        test_frame_err();
        test_relu();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
